// File: rtl/aes_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_spi_pkg
// Description : Shared types and constants for the SPI cipher front end.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_MSG   = 3'd1,
        RX_KEY   = 3'd2,
        WAIT_RES = 3'd3,
        TX       = 3'd4
    } state_t;

    localparam int MSG_W_DEFAULT = 128;
    localparam int CNT_FLOOR     = 256;

    function automatic int KEY_W(input int nk);
        return 32 * nk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : MSB-first shift register, serial-in/parallel-out with
//               parallel load for serial-out.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_en,
    input  logic             i_load_en,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load_en) begin
            r_q <= i_load_data;
        end else if (i_shift_en) begin
            r_q <= {r_q[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_frontend
// Description : Serial frame receiver (message + key) and result transmitter
//               for a block cipher core. SPI_FRAME_PARITY_EN adds a trailing
//               even-parity bit to every received frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_frontend
    import aes_spi_pkg::*;
#(
    parameter int NK    = 4,
    parameter int MSG_W = MSG_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_enc,
    input  logic               Mosi,
    output logic               Miso,
    output logic [MSG_W-1:0]   msg_out,
    output logic [32*NK-1:0]   key_out,
    output logic               blk_valid,
    input  logic [MSG_W-1:0]   res_in,
    input  logic               res_valid,
    output logic               data_done,
    output logic               frame_err
);

    localparam int KEY_BITS = KEY_W(NK);
    localparam int FRAME_W  = MSG_W + KEY_BITS;
`ifdef SPI_FRAME_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int RX_W     = FRAME_W;
`else
    localparam int PAR_BITS = 0;
    // The final frame bit is taken straight from Mosi, so one bit less is stored.
    localparam int RX_W     = FRAME_W - 1;
`endif
    localparam int CNT_MAX  = ((MSG_W > CNT_FLOOR) ? MSG_W : CNT_FLOOR) + PAR_BITS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_msg_last = CNT_W'(MSG_W - 1);
    localparam logic [CNT_W-1:0] c_key_last = CNT_W'(KEY_BITS - 1 + PAR_BITS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_shift;
    logic               w_tx_load;
    logic               w_out_load;
    logic               w_err_set;
    logic               w_done_set;
    logic [RX_W-1:0]    w_sr_q;
    logic [RX_W-1:0]    w_load_data;
    logic [FRAME_W-1:0] w_frame;
    logic               r_blk_valid;
    logic               r_data_done;
    logic               r_frame_err;
    logic [MSG_W-1:0]   r_msg;
    logic [KEY_BITS-1:0] r_key;

    // One register serves both directions: RX contents are copied out before TX loads.
    assign w_load_data = {res_in, {(RX_W - MSG_W){1'b0}}};

    spi_shift_reg #(
        .WIDTH (RX_W)
    ) u_shift_reg (
        .clk         (clk),
        .rst         (rst),
        .i_shift_en  (w_shift),
        .i_load_en   (w_tx_load),
        .i_load_data (w_load_data),
        .i_serial_in (Mosi),
        .o_q         (w_sr_q)
    );

`ifdef SPI_FRAME_PARITY_EN
    logic r_par;

    assign w_frame = w_sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_shift && (r_state != TX)) begin
            r_par <= ((r_state == IDLE) ? 1'b0 : r_par) ^ Mosi;
        end
    end
`else
    assign w_frame = {w_sr_q, Mosi};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_tx_load   = 1'b0;
        w_out_load  = 1'b0;
        w_err_set   = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cs_enc) begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = RX_MSG;
                end
            end
            RX_MSG: begin
                if (!cs_enc) begin
                    w_err_set   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_shift = 1'b1;
                    if (r_cnt == c_msg_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = RX_KEY;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            RX_KEY: begin
                if (!cs_enc) begin
                    w_err_set   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_key_last) begin
                    w_cnt_nxt = '0;
`ifdef SPI_FRAME_PARITY_EN
                    if (r_par == Mosi) begin
                        w_out_load  = 1'b1;
                        w_state_nxt = WAIT_RES;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = IDLE;
                    end
`else
                    w_shift     = 1'b1;
                    w_out_load  = 1'b1;
                    w_state_nxt = WAIT_RES;
`endif
                end else begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    w_tx_load   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TX;
                end
            end
            TX: begin
                if (cs_enc) begin
                    w_shift = 1'b1;
                    if (r_cnt == c_msg_last) begin
                        w_done_set  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_valid <= 1'b0;
            r_data_done <= 1'b0;
            r_frame_err <= 1'b0;
            r_msg       <= '0;
            r_key       <= '0;
        end else begin
            r_blk_valid <= w_out_load;
            r_data_done <= w_done_set;
            r_frame_err <= w_err_set;
            if (w_out_load) begin
                r_msg <= w_frame[FRAME_W-1 -: MSG_W];
                r_key <= w_frame[KEY_BITS-1:0];
            end
        end
    end

    assign Miso      = (r_state == TX) & w_sr_q[RX_W-1];
    assign msg_out   = r_msg;
    assign key_out   = r_key;
    assign blk_valid = r_blk_valid;
    assign data_done = r_data_done;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_frontend
// Description : Directed bench for spi_slave_frontend (NK=4 and NK=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frontend;

`ifdef SPI_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cs4, mosi4, miso4, blk4, resv4, done4, err4;
    logic [127:0] msg4, res4;
    logic [127:0] key4;
    logic         cs8, mosi8, miso8, blk8, resv8, done8, err8;
    logic [127:0] msg8, res8;
    logic [255:0] key8o;

    spi_slave_frontend #(.NK(4), .MSG_W(128)) u_dut4 (
        .clk(clk), .rst(rst), .cs_enc(cs4), .Mosi(mosi4), .Miso(miso4),
        .msg_out(msg4), .key_out(key4), .blk_valid(blk4), .res_in(res4),
        .res_valid(resv4), .data_done(done4), .frame_err(err4)
    );

    spi_slave_frontend #(.NK(8), .MSG_W(128)) u_dut8 (
        .clk(clk), .rst(rst), .cs_enc(cs8), .Mosi(mosi8), .Miso(miso8),
        .msg_out(msg8), .key_out(key8o), .blk_valid(blk8), .res_in(res8),
        .res_valid(resv8), .data_done(done8), .frame_err(err8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_early;
    int n_pulse;

    logic [127:0] msg_a, key_a, msg_b, key_b, res_a, res_b, res_ones;
    logic [255:0] key_c;
    logic [127:0] stream;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic send_frame(input bit use8, input logic [383:0] f, input int flen,
                              input int nbits, input bit bad_par);
        logic b;
        logic par;
        par = (^f) ^ bad_par;
        n_early = 0;
        for (int i = 0; i < nbits; i++) begin
            b = (i < flen) ? f[flen-1-i] : par;
            if (use8) begin cs8 = 1'b1; mosi8 = b; end
            else      begin cs4 = 1'b1; mosi4 = b; end
            tick();
            if (i < nbits - 1) begin
                if (use8) n_early += int'(blk8 | err8);
                else      n_early += int'(blk4 | err4);
            end
        end
        cs4 = 1'b0; mosi4 = 1'b0; cs8 = 1'b0; mosi8 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cs4 = 1'b0; mosi4 = 1'b0; res4 = '0; resv4 = 1'b0;
        cs8 = 1'b0; mosi8 = 1'b0; res8 = '0; resv8 = 1'b0;
        msg_a    = 128'h00112233445566778899aabbccddeeff;
        key_a    = 128'h000102030405060708090a0b0c0d0e0f;
        msg_b    = 128'h3243f6a8885a308d313198a2e0370734;
        key_b    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        res_a    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        res_b    = 128'h3925841d02dc09fbdc118597196a0b32;
        res_ones = '1;
        key_c    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        repeat (3) tick();

        check_eq("rst_blk",   256'(blk4),  256'(0));
        check_eq("rst_err",   256'(err4),  256'(0));
        check_eq("rst_done",  256'(done4), 256'(0));
        check_eq("rst_miso",  256'(miso4), 256'(0));
        check_eq("rst_msg",   256'(msg4),  256'(0));
        check_eq("rst_key",   256'(key4),  256'(0));
        rst = 1'b0;

        res4 = res_ones; resv4 = 1'b1;
        tick();
        resv4 = 1'b0;
        tick();
        check_eq("idle_resv_miso", 256'(miso4), 256'(0));

        send_frame(1'b0, {128'b0, msg_a, key_a}, 256, 256 + PB, 1'b0);
        check_eq("a_no_early", 256'(n_early), 256'(0));
        check_eq("a_blk",      256'(blk4),    256'(1));
        check_eq("a_msg",      256'(msg4),    256'(msg_a));
        check_eq("a_key",      256'(key4),    256'(key_a));
        tick();
        check_eq("a_blk_pulse", 256'(blk4), 256'(0));
        check_eq("a_msg_hold",  256'(msg4), 256'(msg_a));

        cs4 = 1'b1; mosi4 = 1'b1;
        repeat (3) tick();
        cs4 = 1'b0; mosi4 = 1'b0;
        check_eq("wait_miso", 256'(miso4), 256'(0));
        check_eq("wait_err",  256'(err4),  256'(0));

        res4 = res_a; resv4 = 1'b1;
        tick();
        resv4 = 1'b0;
        check_eq("tx_first_hold", 256'(miso4), 256'(res_a[127]));
        n_pulse = 0;
        for (int i = 0; i < 128; i++) begin
            if (i == 64) begin
                cs4 = 1'b0;
                tick();
                tick();
                check_eq("tx_gap_hold", 256'(miso4), 256'(res_a[63]));
            end
            cs4 = 1'b1;
            stream[127-i] = miso4;
            tick();
            if (i < 127) n_pulse += int'(done4);
        end
        check_eq("tx_stream",     256'(stream),  256'(res_a));
        check_eq("tx_no_early",   256'(n_pulse), 256'(0));
        check_eq("tx_done",       256'(done4),   256'(1));
        check_eq("tx_idle_miso",  256'(miso4),   256'(0));
        cs4 = 1'b0;
        tick();
        check_eq("tx_done_pulse", 256'(done4), 256'(0));

        send_frame(1'b0, {128'b0, msg_b, key_b}, 256, 70, 1'b0);
        tick();
        check_eq("abort_err",      256'(err4), 256'(1));
        check_eq("abort_blk",      256'(blk4), 256'(0));
        check_eq("abort_msg_hold", 256'(msg4), 256'(msg_a));
        check_eq("abort_key_hold", 256'(key4), 256'(key_a));
        tick();
        check_eq("abort_err_pulse", 256'(err4), 256'(0));

        send_frame(1'b0, {128'b0, msg_b, key_b}, 256, 256 + PB, 1'b0);
        check_eq("b_no_early", 256'(n_early), 256'(0));
        check_eq("b_blk",      256'(blk4),    256'(1));
        check_eq("b_msg",      256'(msg4),    256'(msg_b));
        check_eq("b_key",      256'(key4),    256'(key_b));

        send_frame(1'b1, {msg_a, key_c}, 384, 384 + PB, 1'b0);
        check_eq("nk8_no_early", 256'(n_early), 256'(0));
        check_eq("nk8_blk",      256'(blk8),    256'(1));
        check_eq("nk8_key",      key8o,         key_c);
        check_eq("nk8_msg",      256'(msg8),    256'(msg_a));
        check_eq("nk8_err",      256'(err8),    256'(0));
        check_eq("nk8_miso",     256'(miso8),   256'(0));
        check_eq("nk8_done",     256'(done8),   256'(0));

        res4 = res_b; resv4 = 1'b1;
        tick();
        resv4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cs4 = 1'b1;
            tick();
        end
        check_eq("tx40_miso", 256'(miso4), 256'(res_b[87]));
        rst = 1'b1;
        tick();
        rst = 1'b0; cs4 = 1'b0;
        check_eq("txrst_miso", 256'(miso4), 256'(0));
        check_eq("txrst_msg",  256'(msg4),  256'(0));
        check_eq("txrst_key",  256'(key4),  256'(0));
        check_eq("txrst_blk",  256'(blk4),  256'(0));
        check_eq("txrst_done", 256'(done4), 256'(0));
        check_eq("txrst_err",  256'(err4),  256'(0));
        n_pulse = 0;
        repeat (4) begin
            tick();
            n_pulse += int'(done4 | err4 | blk4 | miso4);
        end
        check_eq("txrst_quiet", 256'(n_pulse), 256'(0));

`ifdef SPI_FRAME_PARITY_EN
        send_frame(1'b0, {128'b0, msg_a, key_a}, 256, 257, 1'b1);
        check_eq("par_bad_early", 256'(n_early), 256'(0));
        check_eq("par_bad_err",   256'(err4),    256'(1));
        check_eq("par_bad_blk",   256'(blk4),    256'(0));
        check_eq("par_bad_msg",   256'(msg4),    256'(0));
        tick();
        send_frame(1'b0, {128'b0, msg_a, key_a}, 256, 257, 1'b0);
        check_eq("par_ok_blk", 256'(blk4), 256'(1));
        check_eq("par_ok_err", 256'(err4), 256'(0));
        check_eq("par_ok_msg", 256'(msg4), 256'(msg_a));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
